// File: rtl/onehot_regfile_pkg.sv
// Shared constants, types and helpers for the one-hot read register file.
package onehot_regfile_pkg;

    localparam int MAX_REGS = 32;
    localparam int MAX_AW   = 5;

    // Enables the sticky integrity flag on the read-select register.
    localparam bit oh_err_check = 1'b1;

    typedef logic [MAX_REGS-1:0] rd_sel_max_t;

    function automatic int addr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic rd_sel_max_t onehot_of(input logic [MAX_AW-1:0] idx);
        rd_sel_max_t sel;
        sel      = '0;
        sel[idx] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/onehot_regfile_if.sv
// Write port, read port and status bundle of the one-hot read register file.
interface onehot_regfile_if #(
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = 8
);
    import onehot_regfile_pkg::*;

    localparam int AW = addr_w(NUM_REGS);

    logic              wr_en_i;
    logic [AW-1:0]     wr_addr_i;
    logic [DATA_W-1:0] wr_data_i;
    logic              rd_req_i;
    logic [AW-1:0]     rd_addr_i;
    logic              rd_valid_o;
    logic [DATA_W-1:0] rd_data_o;
    logic              addr_err_o;
    logic              oh_err_o;

    modport master (
        output wr_en_i, wr_addr_i, wr_data_i, rd_req_i, rd_addr_i,
        input  rd_valid_o, rd_data_o, addr_err_o, oh_err_o
    );

    modport slave (
        input  wr_en_i, wr_addr_i, wr_data_i, rd_req_i, rd_addr_i,
        output rd_valid_o, rd_data_o, addr_err_o, oh_err_o
    );

endinterface

// File: rtl/onehot_regfile_onehot_check.sv
// Combinational population check of a select vector: zero, one, or more bits set.
module onehot_check #(
    parameter int W = 4
) (
    input  logic [W-1:0] vec,
    output logic         multi_hot,
    output logic         nonzero
);

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_hot = |(vec & (vec - W'(1)));
    assign nonzero   = |vec;

endmodule

// File: rtl/onehot_regfile.sv
// Register file with a registered one-hot read select feeding an AND-OR mux,
// plus a sticky integrity flag on the select register.
module onehot_regfile
    import onehot_regfile_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_REGS*DATA_W-1:0] init_data_i,
    onehot_regfile_if.slave            bus
);

    localparam int             AW         = addr_w(NUM_REGS);
    localparam logic [AW:0]    NUM_REGS_W = (AW+1)'(NUM_REGS);

    typedef logic [NUM_REGS-1:0]             rd_sel_t;
    typedef logic [NUM_REGS-1:0][DATA_W-1:0] reg_arr_t;

    reg_arr_t    regs_q, regs_d;
    rd_sel_t     oh_sel_q, oh_sel_d;
    logic        rd_valid_q, rd_valid_d;
    logic        addr_err_q, addr_err_d;
    logic        oh_err_q, oh_err_d;

    logic        wr_ok, rd_ok;
    logic        multi_hot, nonzero, oh_bad;
    reg_arr_t    and_terms;
    logic [DATA_W-1:0] mux_or;

    onehot_check #(.W(NUM_REGS)) u_check (
        .vec       (oh_sel_q),
        .multi_hot (multi_hot),
        .nonzero   (nonzero)
    );

    // A select bit without a pending valid read is as suspicious as two bits set.
    assign oh_bad = multi_hot || (nonzero && !rd_valid_q);

    always_comb begin
        wr_ok = bus.wr_en_i  && ({1'b0, bus.wr_addr_i} < NUM_REGS_W);
        rd_ok = bus.rd_req_i && ({1'b0, bus.rd_addr_i} < NUM_REGS_W);

        regs_d = regs_q;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (wr_ok && (bus.wr_addr_i == AW'(k))) begin
                regs_d[k] = bus.wr_data_i;
            end
        end

        oh_sel_d   = rd_ok ? rd_sel_t'(onehot_of(MAX_AW'(bus.rd_addr_i))) : '0;
        rd_valid_d = bus.rd_req_i;
        addr_err_d = (bus.rd_req_i && !rd_ok) || (bus.wr_en_i && !wr_ok);
        oh_err_d   = oh_err_q || (oh_err_check && oh_bad);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            regs_q     <= init_data_i;
            oh_sel_q   <= '0;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
            oh_err_q   <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            oh_sel_q   <= oh_sel_d;
            rd_valid_q <= rd_valid_d;
            addr_err_q <= addr_err_d;
            oh_err_q   <= oh_err_d;
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_and
        assign and_terms[k] = regs_q[k] & {DATA_W{oh_sel_q[k]}};
    end

    always_comb begin
        mux_or = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            mux_or = mux_or | and_terms[k];
        end
    end

    assign bus.rd_valid_o = rd_valid_q;
    assign bus.rd_data_o  = oh_bad ? '0 : mux_or;
    assign bus.addr_err_o = addr_err_q;
    assign bus.oh_err_o   = oh_err_q;

endmodule

// File: tb/tb_onehot_regfile.sv
// Scoreboard bench for onehot_regfile: a 4-entry and a 5-entry instance share clock and reset.
module tb_onehot_regfile;

    typedef struct packed {
        logic [7:0] data;
        logic       aerr;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] init4;
    logic [39:0] init5;

    int checks;
    int failures;

    exp_t q4[$];
    exp_t q5[$];

    onehot_regfile_if #(.NUM_REGS(4), .DATA_W(8)) if4 ();
    onehot_regfile_if #(.NUM_REGS(5), .DATA_W(8)) if5 ();

    onehot_regfile #(.NUM_REGS(4), .DATA_W(8)) u_dut4 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .init_data_i (init4),
        .bus         (if4)
    );

    onehot_regfile #(.NUM_REGS(5), .DATA_W(8)) u_dut5 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .init_data_i (init5),
        .bus         (if5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : mon4
        exp_t e;
        if (if4.rd_valid_o === 1'b1) begin
            if (q4.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd4_unexpected: got valid data 0x%0h expected no read", if4.rd_data_o);
            end else begin
                e = q4.pop_front();
                chk("rd4_data", 32'(if4.rd_data_o), 32'(e.data));
                chk("rd4_aerr", 32'(if4.addr_err_o), 32'(e.aerr));
            end
        end
    end

    always @(negedge clk) begin : mon5
        exp_t e;
        if (if5.rd_valid_o === 1'b1) begin
            if (q5.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd5_unexpected: got valid data 0x%0h expected no read", if5.rd_data_o);
            end else begin
                e = q5.pop_front();
                chk("rd5_data", 32'(if5.rd_data_o), 32'(e.data));
                chk("rd5_aerr", 32'(if5.addr_err_o), 32'(e.aerr));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        if4.rd_req_i = 1'b0;
        if4.wr_en_i  = 1'b0;
        if5.rd_req_i = 1'b0;
        if5.wr_en_i  = 1'b0;
    endtask

    task automatic rd4(input logic [1:0] a, input logic [7:0] d);
        if4.rd_req_i  = 1'b1;
        if4.rd_addr_i = a;
        q4.push_back('{data: d, aerr: 1'b0});
    endtask

    task automatic wr4(input logic [1:0] a, input logic [7:0] d);
        if4.wr_en_i   = 1'b1;
        if4.wr_addr_i = a;
        if4.wr_data_i = d;
    endtask

    task automatic rd5(input logic [2:0] a, input logic [7:0] d, input logic aerr);
        if5.rd_req_i  = 1'b1;
        if5.rd_addr_i = a;
        q5.push_back('{data: d, aerr: aerr});
    endtask

    task automatic wr5(input logic [2:0] a, input logic [7:0] d);
        if5.wr_en_i   = 1'b1;
        if5.wr_addr_i = a;
        if5.wr_data_i = d;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        init4    = 32'h4433_2211;
        init5    = 40'h55_4433_2211;
        idle_all();
        if4.rd_addr_i = '0; if4.wr_addr_i = '0; if4.wr_data_i = '0;
        if5.rd_addr_i = '0; if5.wr_addr_i = '0; if5.wr_data_i = '0;
        tick();
        tick();

        chk("rst_valid4", 32'(if4.rd_valid_o), 32'd0);
        chk("rst_data4",  32'(if4.rd_data_o),  32'd0);
        chk("rst_aerr4",  32'(if4.addr_err_o), 32'd0);
        chk("rst_oherr4", 32'(if4.oh_err_o),   32'd0);
        chk("rst_data5",  32'(if5.rd_data_o),  32'd0);
        rst_n = 1'b1;

        // Single read, then idle
        rd4(2'd2, 8'h33);
        tick();
        idle_all();
        tick();
        chk("idle_valid4", 32'(if4.rd_valid_o), 32'd0);
        chk("idle_data4",  32'(if4.rd_data_o),  32'd0);

        // Write-first on the same edge, then back-to-back reads
        wr4(2'd1, 8'hA5);
        rd4(2'd1, 8'hA5);
        tick();
        idle_all();
        rd4(2'd0, 8'h11); tick();
        rd4(2'd1, 8'hA5); tick();
        rd4(2'd2, 8'h33); tick();
        rd4(2'd3, 8'h44); tick();
        idle_all();
        tick();

        // Out-of-range accesses on the 5-entry instance
        rd5(3'd6, 8'h00, 1'b1);
        tick();
        chk("oob_rd_pulse", 32'(if5.addr_err_o), 32'd1);
        idle_all();
        tick();
        chk("oob_rd_clear", 32'(if5.addr_err_o), 32'd0);

        wr5(3'd7, 8'hEE);
        tick();
        chk("oob_wr_pulse", 32'(if5.addr_err_o), 32'd1);
        chk("oob_wr_novld", 32'(if5.rd_valid_o), 32'd0);
        idle_all();
        tick();
        chk("oob_wr_clear", 32'(if5.addr_err_o), 32'd0);

        rd5(3'd7, 8'h00, 1'b1);
        wr5(3'd5, 8'h77);
        tick();
        chk("oob_both_pulse", 32'(if5.addr_err_o), 32'd1);
        idle_all();
        tick();
        chk("oob_both_clear", 32'(if5.addr_err_o), 32'd0);

        wr5(3'd4, 8'h9C);
        tick();
        chk("inrange_wr_noerr", 32'(if5.addr_err_o), 32'd0);
        idle_all();
        rd5(3'd0, 8'h11, 1'b0); tick();
        rd5(3'd1, 8'h22, 1'b0); tick();
        rd5(3'd2, 8'h33, 1'b0); tick();
        rd5(3'd3, 8'h44, 1'b0); tick();
        rd5(3'd4, 8'h9C, 1'b0); tick();
        idle_all();
        tick();

        // Corrupt the select register during a valid read
        rd4(2'd1, 8'h00);
        tick();
        force u_dut4.oh_sel_q = 4'b0110;
        idle_all();
        chk("oherr_before", 32'(if4.oh_err_o), 32'd0);
        tick();
        release u_dut4.oh_sel_q;
        chk("oherr_set", 32'(if4.oh_err_o), 32'd1);
        tick();
        chk("oherr_hold1", 32'(if4.oh_err_o), 32'd1);
        rd4(2'd3, 8'h44); tick();
        rd4(2'd0, 8'h11); tick();
        idle_all();
        chk("oherr_hold2", 32'(if4.oh_err_o), 32'd1);
        tick();
        chk("oherr_hold3", 32'(if4.oh_err_o), 32'd1);

        // Reset in the cycle after a read request, with new init values
        rd4(2'd2, 8'h33);
        tick();
        idle_all();
        rst_n = 1'b0;
        init4 = 32'hDDCC_BBAA;
        tick();
        chk("rrst_valid4", 32'(if4.rd_valid_o), 32'd0);
        chk("rrst_data4",  32'(if4.rd_data_o),  32'd0);
        chk("rrst_oherr4", 32'(if4.oh_err_o),   32'd0);
        chk("rrst_aerr4",  32'(if4.addr_err_o), 32'd0);
        rst_n = 1'b1;
        rd4(2'd0, 8'hAA); tick();
        rd4(2'd1, 8'hBB); tick();
        rd4(2'd2, 8'hCC); tick();
        rd4(2'd3, 8'hDD); tick();
        idle_all();
        tick();
        tick();

        chk("q4_drained", 32'(q4.size()), 32'd0);
        chk("q5_drained", 32'(q5.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
